// File: rtl/seq_shift_add_mac_pkg.sv
// Shared definitions for the sequential shift-add multiply-accumulate lane.
//   state_t   : controller states (idle, shifting, completion pulse)
//   DEF_WIDTH : default operand width
//   DEF_ACC_W : default accumulator width
package seq_shift_add_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_ACC_W = 20;

endpackage

// File: rtl/seq_shift_add_mac_shift_add_core.sv
// Unsigned shift-add datapath: one conditional add + right shift per step.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture mag_a into the low half of the shift register,
//                mag_b as the addend, and preset the step counter
//   step       : perform one add/shift and decrement the counter
//   mag_a/b    : unsigned operand magnitudes
//   last       : current step is the final one
//   mag_next   : shift-register value after the current step (the full
//                magnitude product when last is high)
module shift_add_core
    import seq_shift_add_mac_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   mag_next
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    // {upper (WIDTH+1 bits, absorbs the add carry), lower (WIDTH bits)}
    logic [2*WIDTH:0] sr;
    logic [2*WIDTH:0] sr_next;
    logic [WIDTH-1:0] mb;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   upper_sum;

    always_comb begin
        upper_sum = sr[2*WIDTH:WIDTH] + {1'b0, mb};
        if (sr[0]) begin
            sr_next = {1'b0, upper_sum, sr[WIDTH-1:1]};
        end else begin
            sr_next = {1'b0, sr[2*WIDTH:1]};
        end
        mag_next = sr_next[2*WIDTH-1:0];
        last     = (cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            mb  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {{(WIDTH+1){1'b0}}, mag_a};
            mb  <= mag_b;
            cnt <= CW'(WIDTH);
        end else if (step) begin
            sr  <= sr_next;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/seq_shift_add_mac.sv
// Sequential shift-add multiplier with signed/unsigned mode and running
// accumulator; one instance per lane of the int8 vector MAC.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : request, accepted only while idle
//   signed_mode  : operands are two's complement (captured with start)
//   acc_en       : add the product into acc_out on completion (captured)
//   acc_clr      : synchronous clear of acc_out and ovf
//   a, b         : operands (captured with start)
//   busy         : operation in progress, through the done cycle
//   done         : one-cycle completion pulse
//   product      : last product, 2*WIDTH bits
//   acc_out      : running accumulator, wraps modulo 2^ACC_W
//   ovf          : sticky accumulate overflow
module seq_shift_add_mac
    import seq_shift_add_mac_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 ovf
);

    state_t state, state_next;

    logic               load, step, finish, last;
    logic               neg_q, signed_q, acc_en_q;
    logic [WIDTH:0]     a_ext, b_ext, a_abs, b_abs;
    logic [2*WIDTH-1:0] mag_next, prod_next;
    logic [ACC_W-1:0]   acc_base, acc_add, acc_sum;
    logic               carry, ovf_now;

    // Magnitudes are formed on WIDTH+1 bits so the most negative operand
    // still yields a representable WIDTH-bit magnitude.
    always_comb begin
        a_ext = {signed_mode & a[WIDTH-1], a};
        b_ext = {signed_mode & b[WIDTH-1], b};
        a_abs = a_ext[WIDTH] ? -a_ext : a_ext;
        b_abs = b_ext[WIDTH] ? -b_ext : b_ext;
    end

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .mag_a    (a_abs[WIDTH-1:0]),
        .mag_b    (b_abs[WIDTH-1:0]),
        .last     (last),
        .mag_next (mag_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Product and accumulator are written on the edge that enters DONE so
    // they are already valid while done is high; an acc_clr sampled on that
    // same edge clears the old total before the new product is added.
    always_comb begin
        prod_next = neg_q ? -mag_next : mag_next;
        acc_add   = signed_q ? ACC_W'($signed(prod_next)) : ACC_W'(prod_next);
        acc_base  = acc_clr ? '0 : acc_out;
        {carry, acc_sum} = {1'b0, acc_base} + {1'b0, acc_add};
        if (signed_q) begin
            ovf_now = (acc_base[ACC_W-1] == acc_add[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
        end else begin
            ovf_now = carry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
            acc_en_q <= 1'b0;
            product  <= '0;
            acc_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            if (load) begin
                neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                signed_q <= signed_mode;
                acc_en_q <= acc_en;
            end
            if (finish) begin
                product <= prod_next;
            end
            if (finish && acc_en_q) begin
                acc_out <= acc_sum;
                ovf     <= (ovf & ~acc_clr) | ovf_now;
            end else if (acc_clr) begin
                acc_out <= '0;
                ovf     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mac.sv
module tb_seq_shift_add_mac;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic        acc_en;
    logic        acc_clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [19:0] acc_out;
    logic        ovf;

    int total;
    int bad;

    seq_shift_add_mac #(
        .WIDTH (8),
        .ACC_W (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .acc_out     (acc_out),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from idle and wait for done (bounded).
    // Returns the number of rising edges from the accepting edge to the
    // first edge after which done is seen; ends inside the done cycle.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            input logic sm, input logic ae, output int lat);
        @(posedge clk);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm; acc_en = ae; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (product !== 16'h0) begin bad++; $display("FAIL reset_product got=%h exp=0000", product); end
        total++; if (acc_out !== 20'h0) begin bad++; $display("FAIL reset_acc got=%h exp=00000", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // 13 * 11 unsigned; busy/done tracked edge by edge.
    task automatic test_unsigned;
        @(posedge clk);
        @(negedge clk);
        a = 8'd13; b = 8'd11; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            total++;
            if (busy !== (k <= 9)) begin
                bad++; $display("FAIL unsigned_busy edge=%0d got=%b exp=%b", k, busy, (k <= 9));
            end
            total++;
            if (done !== (k == 9)) begin
                bad++; $display("FAIL unsigned_done edge=%0d got=%b exp=%b", k, done, (k == 9));
            end
            if (k == 9) begin
                total++;
                if (product !== 16'd143) begin
                    bad++; $display("FAIL unsigned_product got=%0d exp=143", product);
                end
            end
        end
    endtask

    task automatic test_signed;
        int lat;
        start_op(8'h80, 8'h80, 1'b1, 1'b0, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL signed_lat got=%0d exp=9", lat); end
        total++; if (product !== 16'h4000) begin bad++; $display("FAIL signed_m128_m128 got=%h exp=4000", product); end
        start_op(8'h80, 8'h7F, 1'b1, 1'b0, lat);
        total++; if (product !== 16'hC080) begin bad++; $display("FAIL signed_m128_127 got=%h exp=c080", product); end
        start_op(8'h00, 8'hFB, 1'b1, 1'b0, lat);
        total++; if (product !== 16'h0000) begin bad++; $display("FAIL signed_0_m5 got=%h exp=0000", product); end
        total++; if (acc_out !== 20'h0) begin bad++; $display("FAIL signed_no_acc got=%h exp=00000", acc_out); end
    endtask

    task automatic test_accumulate;
        int lat;
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        total++; if (acc_out !== 20'h0) begin bad++; $display("FAIL acc_clear got=%h exp=00000", acc_out); end
        start_op(8'hFD, 8'h07, 1'b1, 1'b1, lat);
        total++; if (product !== 16'hFFEB) begin bad++; $display("FAIL acc_prod1 got=%h exp=ffeb", product); end
        total++; if (acc_out !== 20'hFFFEB) begin bad++; $display("FAIL acc_sum1 got=%h exp=fffeb", acc_out); end
        start_op(8'h05, 8'h05, 1'b1, 1'b1, lat);
        total++; if (acc_out !== 20'h00004) begin bad++; $display("FAIL acc_sum2 got=%h exp=00004", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL acc_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_overflow;
        int lat;
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            start_op(8'hFF, 8'hFF, 1'b0, 1'b1, lat);
            total++;
            if (lat !== 9) begin bad++; $display("FAIL ovf_lat op=%0d got=%0d exp=9", i, lat); end
            if (i == 16) begin
                total++; if (acc_out !== 20'd1040400) begin bad++; $display("FAIL ovf_acc16 got=%0d exp=1040400", acc_out); end
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_flag16 got=%b exp=0", ovf); end
            end
        end
        total++; if (acc_out !== 20'd56849) begin bad++; $display("FAIL ovf_acc17 got=%0d exp=56849", acc_out); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag17 got=%b exp=1", ovf); end
        @(negedge clk);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        total++; if (acc_out !== 20'h0) begin bad++; $display("FAIL ovf_clr_acc got=%h exp=00000", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr_flag got=%b exp=0", ovf); end
    endtask

    task automatic test_back_to_back;
        int pos[$];
        int lat;
        int seen;
        // start held high: one op every 10 cycles
        @(posedge clk);
        @(negedge clk);
        a = 8'd3; b = 8'd4; signed_mode = 1'b0; acc_en = 1'b0; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) pos.push_back(k);
        end
        start = 1'b0;
        total++;
        if (pos.size() !== 3) begin
            bad++; $display("FAIL b2b_count got=%0d exp=3", pos.size());
        end else begin
            total++; if (pos[0] !== 9)  begin bad++; $display("FAIL b2b_pos0 got=%0d exp=9", pos[0]); end
            total++; if (pos[1] !== 19) begin bad++; $display("FAIL b2b_pos1 got=%0d exp=19", pos[1]); end
            total++; if (pos[2] !== 29) begin bad++; $display("FAIL b2b_pos2 got=%0d exp=29", pos[2]); end
        end
        total++; if (product !== 16'd12) begin bad++; $display("FAIL b2b_product got=%0d exp=12", product); end

        // start pulse while busy is ignored
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'd10; b = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (product !== 16'd100) begin bad++; $display("FAIL busy_start_product got=%0d exp=100", product); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL busy_start_extra_done got=%0d exp=0", seen); end

        // acc_clr sampled on the completing edge: total restarts at product
        start_op(8'd2, 8'd3, 1'b0, 1'b1, lat);
        total++; if (acc_out !== 20'd6) begin bad++; $display("FAIL clr_pre_acc got=%0d exp=6", acc_out); end
        @(posedge clk);
        @(negedge clk);
        a = 8'd6; b = 8'd7; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            acc_clr = 1'b0;
            if (k == 8) begin
                @(negedge clk);
                acc_clr = 1'b1;
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL clr_done got=%b exp=1", done); end
        total++; if (acc_out !== 20'd42) begin bad++; $display("FAIL clr_done_acc got=%0d exp=42", acc_out); end
    endtask

    task automatic test_reset_midrun;
        int lat;
        int seen;
        @(posedge clk);
        @(negedge clk);
        a = 8'd9; b = 8'd9; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (product !== 16'h0) begin bad++; $display("FAIL midrst_product got=%h exp=0000", product); end
        total++; if (acc_out !== 20'h0) begin bad++; $display("FAIL midrst_acc got=%h exp=00000", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
        start_op(8'd9, 8'd9, 1'b0, 1'b1, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL midrst_lat got=%0d exp=9", lat); end
        total++; if (product !== 16'd81) begin bad++; $display("FAIL midrst_product2 got=%0d exp=81", product); end
        total++; if (acc_out !== 20'd81) begin bad++; $display("FAIL midrst_acc2 got=%0d exp=81", acc_out); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_accumulate();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
